// File: rtl/pcs_fifo_pkg.sv
// Shared FIFO pointer definitions and the Gray/binary conversions
// used by both clock domains of the PCS elastic FIFO.
package pcs_fifo_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int PTR_W      = 5;
    localparam int ADDR_W     = PTR_W - 1;

    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [ADDR_W-1:0] addr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_wptr_ctrl_16_if.sv
// Write-side bus of the FIFO pointer controller: upstream request,
// RAM strobe/address, cross-domain pointers and status flags.
interface gray_wptr_ctrl_16_if;
    import pcs_fifo_pkg::*;

    logic  wr_req;
    logic  wr_en;
    addr_t wr_addr;
    ptr_t  wr_gray;
    ptr_t  rd_gray_async;
    logic  full;
    logic  afull;
    ptr_t  wr_level;
    logic  ovf;
    logic  ptr_err;
    logic  flag_clr;

    modport master (
        output wr_req, rd_gray_async, flag_clr,
        input  wr_en, wr_addr, wr_gray, full, afull, wr_level, ovf, ptr_err
    );

    modport slave (
        input  wr_req, rd_gray_async, flag_clr,
        output wr_en, wr_addr, wr_gray, full, afull, wr_level, ovf, ptr_err
    );

endinterface

// File: rtl/ptr_sync.sv
// STAGES-deep flop chain that brings the read-domain Gray pointer
// into the write clock domain.
module ptr_sync
    import pcs_fifo_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  ptr_t d,
    output ptr_t q
);

    logic [STAGES-1:0][PTR_W-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            // NOTE: non-blocking, so every stage captures its neighbour's old value and the chain really is STAGES deep.
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_wptr_ctrl_16.sv
// Write-pointer controller for a 16-entry async FIFO: binary/Gray write
// pointer, synchronised read pointer, occupancy and sticky error flags.
module gray_wptr_ctrl_16
    import pcs_fifo_pkg::*;
#(
    parameter int AFULL_THRESH = 12,
    parameter int SYNC_STAGES  = 2
) (
    input logic               clk,
    input logic               rst_n,
    gray_wptr_ctrl_16_if.slave bus
);

    ptr_t wbin;
    ptr_t wbin_next;
    ptr_t wr_gray_q;
    ptr_t rd_gray_s;
    ptr_t rbin_s;
    ptr_t diff;
    ptr_t level;
    logic over;
    logic full;
    logic afull;
    logic wr_en;
    logic ovf_q;
    logic ptr_err_q;

    ptr_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rd_gray_async),
        .q     (rd_gray_s)
    );

    // NOTE: every signal is assigned on every pass, so no latch can be inferred.
    always_comb begin
        rbin_s    = gray2bin(rd_gray_s);
        diff      = wbin - rbin_s;
        over      = diff > ptr_t'(FIFO_DEPTH);
        level     = over ? ptr_t'(FIFO_DEPTH) : diff;
        full      = (level == ptr_t'(FIFO_DEPTH));
        afull     = (level >= ptr_t'(AFULL_THRESH));
        // rst_n gates the strobe so the RAM sees no write while held in reset.
        wr_en     = rst_n & bus.wr_req & ~full;
        wbin_next = wbin + ptr_t'(wr_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin      <= '0;
            wr_gray_q <= '0;
        end else begin
            wbin      <= wbin_next;
            wr_gray_q <= bin2gray(wbin_next);
        end
    end

    // Sticky flags: a set in the same cycle as flag_clr takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q     <= 1'b0;
            ptr_err_q <= 1'b0;
        end else begin
            if (bus.wr_req && full) begin
                ovf_q <= 1'b1;
            end else if (bus.flag_clr) begin
                ovf_q <= 1'b0;
            end

            if (over) begin
                ptr_err_q <= 1'b1;
            end else if (bus.flag_clr) begin
                ptr_err_q <= 1'b0;
            end
        end
    end

    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = wbin[ADDR_W-1:0];
    assign bus.wr_gray  = wr_gray_q;
    assign bus.wr_level = level;
    assign bus.full     = full;
    assign bus.afull    = afull;
    assign bus.ovf      = ovf_q;
    assign bus.ptr_err  = ptr_err_q;

endmodule

// File: tb/tb_gray_wptr_ctrl_16.sv
// Scoreboard bench for gray_wptr_ctrl_16: directed stimulus queues the
// expected per-cycle output vector, a negedge monitor pops and compares.
module tb_gray_wptr_ctrl_16;

    logic clk = 1'b0;
    logic rst_n;

    gray_wptr_ctrl_16_if bus ();

    gray_wptr_ctrl_16 #(
        .AFULL_THRESH (12),
        .SYNC_STAGES  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Packed view: {wr_en, wr_addr, wr_gray, wr_level, full, afull, ovf, ptr_err}
    typedef struct {
        string       tag;
        logic [18:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Gray codes of 0..16, written out by hand.
    logic [4:0] gtab [0:16] = '{
        5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111,
        5'b00101, 5'b00100, 5'b01100, 5'b01101, 5'b01111, 5'b01110,
        5'b01010, 5'b01011, 5'b01001, 5'b01000, 5'b11000
    };

    function automatic logic [4:0] tb_gray(input logic [4:0] b);
        return b ^ {1'b0, b[4:1]};
    endfunction

    function automatic logic [18:0] mk_exp(input logic en, input logic [3:0] addr,
                                           input logic [4:0] gray, input logic [4:0] lvl,
                                           input logic full, input logic afull,
                                           input logic ovf, input logic perr);
        return {en, addr, gray, lvl, full, afull, ovf, perr};
    endfunction

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %b expected %b (en,addr,gray,level,full,afull,ovf,perr)",
                      name, got, want);
    endtask

    task automatic step(input logic req, input logic [4:0] rdg, input logic clr,
                        input string tag, input logic [18:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        bus.wr_req        = req;
        bus.rd_gray_async = rdg;
        bus.flag_clr      = clr;
        x.tag = tag;
        x.v   = e;
        sb.push_back(x);
    endtask

    // Monitor: the DUT presents a full status vector every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check(e.tag, {bus.wr_en, bus.wr_addr, bus.wr_gray, bus.wr_level,
                              bus.full, bus.afull, bus.ovf, bus.ptr_err}, e.v);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t       r;
        logic [4:0] wb;
        logic [4:0] lvl;
        logic [4:0] prev;

        // Reset with wr_req high: the strobe must stay low.
        rst_n             = 1'b0;
        bus.wr_req        = 1'b1;
        bus.rd_gray_async = 5'd0;
        bus.flag_clr      = 1'b0;
        r.tag = "reset";
        r.v   = mk_exp(0, 4'd0, 5'b00000, 5'd0, 0, 0, 0, 0);
        sb.push_back(r);
        #12 rst_n = 1'b1;

        // First edge after release writes entry 0; keep writing up to 16 entries.
        for (int k = 1; k <= 15; k++)
            step(1, 5'd0, 0, "fill", mk_exp(1, 4'(k), gtab[k], 5'(k), 0, k >= 12, 0, 0));
        step(0, 5'd0, 0, "full_after_16", mk_exp(0, 4'd0, gtab[16], 5'd16, 1, 1, 0, 0));

        // Writes while full are dropped and flag overflow.
        step(1, 5'd0, 0, "ovf_drop0",    mk_exp(0, 4'd0, 5'b11000, 5'd16, 1, 1, 0, 0));
        step(1, 5'd0, 0, "ovf_drop1",    mk_exp(0, 4'd0, 5'b11000, 5'd16, 1, 1, 1, 0));
        step(1, 5'd0, 0, "ovf_drop2",    mk_exp(0, 4'd0, 5'b11000, 5'd16, 1, 1, 1, 0));
        step(0, 5'd0, 1, "ovf_clr",      mk_exp(0, 4'd0, 5'b11000, 5'd16, 1, 1, 1, 0));
        step(1, 5'd0, 1, "ovf_set_clr",  mk_exp(0, 4'd0, 5'b11000, 5'd16, 1, 1, 0, 0));
        step(0, 5'd0, 0, "ovf_set_wins", mk_exp(0, 4'd0, 5'b11000, 5'd16, 1, 1, 1, 0));
        step(0, 5'd0, 1, "ovf_clr2",     mk_exp(0, 4'd0, 5'b11000, 5'd16, 1, 1, 1, 0));
        step(0, 5'd0, 0, "ovf_cleared",  mk_exp(0, 4'd0, 5'b11000, 5'd16, 1, 1, 0, 0));

        // Read pointer advances to 4, then 5: two-cycle synchroniser latency.
        step(0, 5'b00110, 0, "rd4_c0", mk_exp(0, 4'd0, 5'b11000, 5'd16, 1, 1, 0, 0));
        step(0, 5'b00110, 0, "rd4_c1", mk_exp(0, 4'd0, 5'b11000, 5'd16, 1, 1, 0, 0));
        step(0, 5'b00110, 0, "rd4_c2", mk_exp(0, 4'd0, 5'b11000, 5'd12, 0, 1, 0, 0));
        step(0, 5'b00111, 0, "rd5_c0", mk_exp(0, 4'd0, 5'b11000, 5'd12, 0, 1, 0, 0));
        step(0, 5'b00111, 0, "rd5_c1", mk_exp(0, 4'd0, 5'b11000, 5'd12, 0, 1, 0, 0));
        step(0, 5'b00111, 0, "rd5_c2", mk_exp(0, 4'd0, 5'b11000, 5'd11, 0, 0, 0, 0));

        // Streaming: write and read every cycle for 40 entries, crossing 31->0.
        prev = 5'b11000;
        for (int j = 0; j < 40; j++) begin
            wb  = 5'(16 + j);
            lvl = (j == 0) ? 5'd11 : 5'd12;
            step(1, tb_gray(5'(6 + j)), 0, "stream",
                 mk_exp(1, wb[3:0], tb_gray(wb), lvl, 0, j != 0, 0, 0));
            if (j > 0) check("hamming", 19'($countones(bus.wr_gray ^ prev)), 19'd1);
            prev = bus.wr_gray;
        end

        // wbin is now 24; drive the illegal read pointer gray(24+8) = gray(0).
        step(0, 5'b00000, 0, "perr_c0",      mk_exp(0, 4'd8, 5'b10100, 5'd12, 0, 1, 0, 0));
        step(0, 5'b00000, 0, "perr_c1",      mk_exp(0, 4'd8, 5'b10100, 5'd11, 0, 0, 0, 0));
        step(0, 5'b00000, 0, "perr_c2",      mk_exp(0, 4'd8, 5'b10100, 5'd16, 1, 1, 0, 0));
        step(0, 5'b10100, 0, "perr_c3",      mk_exp(0, 4'd8, 5'b10100, 5'd16, 1, 1, 0, 1));
        step(0, 5'b10100, 0, "perr_c4",      mk_exp(0, 4'd8, 5'b10100, 5'd16, 1, 1, 0, 1));
        step(0, 5'b10100, 1, "perr_c5",      mk_exp(0, 4'd8, 5'b10100, 5'd0,  0, 0, 0, 1));
        step(0, 5'b10100, 0, "perr_cleared", mk_exp(0, 4'd8, 5'b10100, 5'd0,  0, 0, 0, 0));

        // Burst up to level 7, then pull reset between clock edges.
        for (int k = 0; k <= 6; k++)
            step(1, 5'b10100, 0, "burst",
                 mk_exp(1, 4'(8 + k), tb_gray(5'(24 + k)), 5'(k), 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        r.tag = "async_reset";
        r.v   = mk_exp(0, 4'd0, 5'b00000, 5'd0, 0, 0, 0, 0);
        sb.push_back(r);

        repeat (3) @(negedge clk);
        #1;
        check("drain_empty", 19'(sb.size()), 19'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
